nvram_upload_server: RTL and testbench
======================================

Name: nvram_upload_server

Overview:
- HPS-facing responder that serves ioctl upload reads for the game's battery/hiscore RAM window. It pauses the CPU, fetches bytes through a dedicated RAM port and returns them on ioctl_din, using ioctl_wait for flow control.
- Snoops CPU writes into the window and raises ioctl_upload_req for autosave after the RAM has been quiet for a set time.
- Sits in emu beside hps_io. It is the read-back counterpart of the ROM/ioctl download path.

Parameters:
- NV_INDEX, 8'd4: ioctl_index value this block answers.
- NV_AW, 10: RAM window address width; window size is 2^NV_AW bytes.
- NV_BASE, 16'hC000: CPU address of window byte 0, used for write snooping.
- RAM_LAT, 2: RAM port read latency in clk_sys cycles, range 1..3.
- QUIET_CYC, 24'd10_000_000: write-quiet period before upload_req.

Ports:
- clk_sys  in  1  system clock
- RESET_n  in  1  asynchronous reset, active low
- ioctl_upload  in  1  HPS upload active
- ioctl_index  in  8  current transfer index
- ioctl_rd  in  1  one-cycle read strobe for ioctl_addr
- ioctl_addr  in  25  byte address
- ioctl_din  out  8  byte returned to HPS
- ioctl_wait  out  1  HPS must hold off until low
- ioctl_upload_req  out  1  autosave request pulse
- autosave  in  1  enables upload_req generation
- cpu_wr  in  1  CPU write strobe, used for snooping
- cpu_addr  in  16  CPU address
- pause_req  out  1  requests CPU halt
- paused  in  1  CPU halted acknowledge
- nv_addr  out  NV_AW  RAM port address
- nv_q  in  8  RAM port read data
- nv_we  out  1  RAM port write enable (used only with the optional feature)
- nv_d  out  8  RAM port write data

Behaviour:
- Reset values: ioctl_din=0, ioctl_wait=0, ioctl_upload_req=0, pause_req=0, nv_addr=0, nv_we=0, nv_d=0. The FSM goes to IDLE, the dirty flag clears, the quiet counter clears. Reset is async assert and sync release.
- sel = ioctl_upload && ioctl_index==NV_INDEX.
- FSM states and transitions:
  - IDLE: a rising edge of sel drives pause_req=1 and moves to PAUSE_WAIT.
  - PAUSE_WAIT: ioctl_wait=1 while waiting; on paused=1 go to READY.
  - READY: ioctl_wait=0. ioctl_rd with ioctl_addr < 2^NV_AW latches nv_addr=ioctl_addr[NV_AW-1:0], sets ioctl_wait=1 in the same cycle, loads the latency counter with RAM_LAT and moves to FETCH. ioctl_rd with an address outside the window sets ioctl_din=8'hFF the next cycle, leaves wait low and performs no RAM access.
  - FETCH: count down. When the counter reaches 0, capture nv_q into ioctl_din, drop ioctl_wait and return to READY. Read latency from ioctl_rd to wait low is RAM_LAT+1 cycles.
- Falling edge of sel, from any state: abandon any fetch, set ioctl_wait=0, pause_req=0, go to IDLE, and clear the dirty flag (a save completed).
- A pause_req drop during FETCH completes no access; ioctl_din keeps its last value.
- ioctl_rd arriving while in PAUSE_WAIT or FETCH is ignored. HPS honours ioctl_wait, so this case does not arise in normal operation.
- Dirty tracking:
  - A window hit is cpu_wr && cpu_addr - NV_BASE < 2^NV_AW, using 16-bit unsigned wrap, so addresses below NV_BASE miss.
  - A hit sets dirty and clears the quiet counter.
  - While dirty && autosave && FSM==IDLE, the counter increments and saturates at QUIET_CYC.
  - On reaching QUIET_CYC, ioctl_upload_req pulses for 1 cycle and the counter holds. No further pulse occurs until the next hit.
  - A hit in the same cycle as the terminal count suppresses the pulse; the hit wins.
- Snooping continues while paused. No hits are expected then.

Optional Feature:
- Macro NVRAM_SERVER_RESTORE_EN.
- When defined: adds input ioctl_download, ioctl_wr and ioctl_dout[7:0]. A download on NV_INDEX pauses the CPU the same way, and each in-window ioctl_wr drives nv_we=1, nv_addr and nv_d=ioctl_dout for one cycle, with wait held 1 cycle. Out-of-window writes are dropped. The end of the download releases the pause and clears dirty.
- When undefined: nv_we is tied 0, nv_d is tied 0, and the extra ports are absent.

Decomposition:
- nvram_pkg holds the FSM state enum (IDLE, PAUSE_WAIT, READY, FETCH, WRITE) and the default constants NV_INDEX and QUIET_CYC.
- Sub-module nvram_dirty_timer holds the hit decode, dirty flag, quiet counter and pulse.

Test Plan:
- Upload, index 4, RAM preloaded: byte 0=8'h5A, byte 1023=8'hA5, RAM_LAT=2, paused delayed 5 cycles. Wait stays high until paused; reads return 5A and A5; wait is low 3 cycles after each ioctl_rd.
- Read at ioctl_addr=1024 → ioctl_din=FF next cycle; wait never rises; nv_addr is unchanged.
- Drop ioctl_upload mid-FETCH → next cycle wait=0, pause_req=0, FSM is IDLE, dirty is cleared.
- autosave=1, QUIET_CYC=100, CPU write to 16'hC010 → exactly one upload_req pulse 100 cycles later. A write to 16'hBFFF produces no pulse.
- A CPU write at cycle 99 of the quiet count → the counter restarts; the pulse arrives 100 cycles after the second write.
- With NVRAM_SERVER_RESTORE_EN defined: download 1024 bytes of value addr[7:0] → the RAM contents match; pause is released at the end.

Source files
------------

// File: rtl/nvram_pkg.sv
// nvram_pkg: shared types and default constants for the NVRAM upload server.
package nvram_pkg;

  localparam logic [7:0]  NV_INDEX_DEF  = 8'd4;
  localparam logic [23:0] QUIET_CYC_DEF = 24'd10_000_000;

  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    PAUSE_WAIT = 3'd1,
    READY      = 3'd2,
    FETCH      = 3'd3,
    WRITE      = 3'd4
  } nv_state_e;

endpackage

// File: rtl/nvram_dirty_timer.sv
// nvram_dirty_timer: snoops CPU writes into the NVRAM window, tracks a dirty
// flag and raises a one-cycle autosave request once the RAM has been quiet.
module nvram_dirty_timer
  import nvram_pkg::*;
#(
  parameter int          NV_AW     = 10,
  parameter logic [15:0] NV_BASE   = 16'hC000,
  parameter logic [23:0] QUIET_CYC = QUIET_CYC_DEF
) (
  input  logic        clk_sys,
  input  logic        rst_n,
  input  logic        cpu_wr,
  input  logic [15:0] cpu_addr,
  input  logic        count_en,
  input  logic        save_done,
  output logic        upload_req
);

  logic [15:0] offset;
  logic        hit;
  logic        dirty_q, dirty_d;
  logic [23:0] cnt_q, cnt_d;
  logic        req_q, req_d;

  // 16-bit wrap makes addresses below the base land far outside the window
  assign offset = cpu_addr - NV_BASE;
  assign hit    = cpu_wr && ((offset >> NV_AW) == 16'd0);

  // Next-state: a hit always wins, including over the terminal count
  always_comb begin
    dirty_d = dirty_q;
    cnt_d   = cnt_q;
    req_d   = 1'b0;
    if (hit) begin
      dirty_d = 1'b1;
      cnt_d   = '0;
    end else if (save_done) begin
      dirty_d = 1'b0;
      cnt_d   = '0;
    end else if (dirty_q && count_en && (cnt_q != QUIET_CYC)) begin
      cnt_d = cnt_q + 24'd1;
      req_d = ((cnt_q + 24'd1) == QUIET_CYC);
    end
  end

  // Dirty flag, saturating quiet counter and request pulse
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      dirty_q <= 1'b0;
      cnt_q   <= '0;
      req_q   <= 1'b0;
    end else begin
      dirty_q <= dirty_d;
      cnt_q   <= cnt_d;
      req_q   <= req_d;
    end
  end

  assign upload_req = req_q;

endmodule

// File: rtl/nvram_upload_server.sv
// nvram_upload_server: serves HPS ioctl upload reads of the battery/hiscore
// RAM window, pausing the CPU while the RAM port is borrowed.
// Optional restore (download into the window) under NVRAM_SERVER_RESTORE_EN.
//
// state      | meaning
// IDLE       | not selected; CPU runs, autosave timer may count
// PAUSE_WAIT | pause requested, HPS held off until CPU acknowledges
// READY      | CPU halted, accepting ioctl_rd (and ioctl_wr on restore)
// FETCH      | waiting out RAM read latency, wait held high
// WRITE      | one-cycle RAM write in flight (restore only)
module nvram_upload_server
  import nvram_pkg::*;
#(
  parameter logic [7:0]  NV_INDEX  = NV_INDEX_DEF,
  parameter int          NV_AW     = 10,
  parameter logic [15:0] NV_BASE   = 16'hC000,
  parameter int          RAM_LAT   = 2,
  parameter logic [23:0] QUIET_CYC = QUIET_CYC_DEF
) (
  input  logic             clk_sys,
  input  logic             RESET_n,
  input  logic             ioctl_upload,
`ifdef NVRAM_SERVER_RESTORE_EN
  input  logic             ioctl_download,
  input  logic             ioctl_wr,
  input  logic [7:0]       ioctl_dout,
`endif
  input  logic [7:0]       ioctl_index,
  input  logic             ioctl_rd,
  input  logic [24:0]      ioctl_addr,
  output logic [7:0]       ioctl_din,
  output logic             ioctl_wait,
  output logic             ioctl_upload_req,
  input  logic             autosave,
  input  logic             cpu_wr,
  input  logic [15:0]      cpu_addr,
  output logic             pause_req,
  input  logic             paused,
  output logic [NV_AW-1:0] nv_addr,
  input  logic [7:0]       nv_q,
  output logic             nv_we,
  output logic [7:0]       nv_d
);

  logic [1:0]       rst_sync_q;
  logic             rst_n;
  logic             sel, sel_q, sel_rise, sel_fall, in_win, save_done;
  nv_state_e        state_q, state_d;
  logic             wait_q, wait_d, pause_q, pause_d;
  logic [7:0]       din_q, din_d;
  logic [NV_AW-1:0] addr_q, addr_d;
  logic [1:0]       cnt_q, cnt_d;
`ifdef NVRAM_SERVER_RESTORE_EN
  logic             we_q, we_d;
  logic [7:0]       nvd_q, nvd_d;
`endif

  // Reset synchroniser: assert immediately, release on a clock edge
  always_ff @(posedge clk_sys or negedge RESET_n) begin
    if (!RESET_n) rst_sync_q <= 2'b00;
    else          rst_sync_q <= {rst_sync_q[0], 1'b1};
  end
  assign rst_n = rst_sync_q[1];

`ifdef NVRAM_SERVER_RESTORE_EN
  assign sel = (ioctl_upload || ioctl_download) && (ioctl_index == NV_INDEX);
`else
  assign sel = ioctl_upload && (ioctl_index == NV_INDEX);
`endif
  assign sel_rise = sel && !sel_q;
  assign sel_fall = !sel && sel_q;
  assign in_win   = ((ioctl_addr >> NV_AW) == 25'd0);

  // FSM next-state; losing select abandons whatever is in flight
  always_comb begin
    state_d   = state_q;
    wait_d    = wait_q;
    pause_d   = pause_q;
    din_d     = din_q;
    addr_d    = addr_q;
    cnt_d     = cnt_q;
    save_done = 1'b0;
`ifdef NVRAM_SERVER_RESTORE_EN
    we_d      = 1'b0;
    nvd_d     = nvd_q;
`endif
    if (sel_fall) begin
      state_d   = IDLE;
      wait_d    = 1'b0;
      pause_d   = 1'b0;
      cnt_d     = '0;
      save_done = 1'b1;
    end else begin
      case (state_q)
        IDLE: if (sel_rise) begin
          pause_d = 1'b1;
          wait_d  = 1'b1;
          state_d = PAUSE_WAIT;
        end
        PAUSE_WAIT: if (paused) begin
          wait_d  = 1'b0;
          state_d = READY;
        end
        READY: begin
          if (ioctl_rd) begin
            if (in_win) begin
              addr_d  = ioctl_addr[NV_AW-1:0];
              wait_d  = 1'b1;
              cnt_d   = 2'(RAM_LAT);
              state_d = FETCH;
            end else begin
              din_d = 8'hFF;
            end
          end
`ifdef NVRAM_SERVER_RESTORE_EN
          else if (ioctl_wr && in_win) begin
            addr_d  = ioctl_addr[NV_AW-1:0];
            nvd_d   = ioctl_dout;
            we_d    = 1'b1;
            wait_d  = 1'b1;
            state_d = WRITE;
          end
`endif
        end
        FETCH: begin
          if (cnt_q == 2'd0) begin
            din_d   = nv_q;
            wait_d  = 1'b0;
            state_d = READY;
          end else begin
            cnt_d = cnt_q - 2'd1;
          end
        end
        WRITE: begin
          wait_d  = 1'b0;
          state_d = READY;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // FSM state and registered outputs
  always_ff @(posedge clk_sys or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sel_q   <= 1'b0;
      wait_q  <= 1'b0;
      pause_q <= 1'b0;
      din_q   <= '0;
      addr_q  <= '0;
      cnt_q   <= '0;
`ifdef NVRAM_SERVER_RESTORE_EN
      we_q    <= 1'b0;
      nvd_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      sel_q   <= sel;
      wait_q  <= wait_d;
      pause_q <= pause_d;
      din_q   <= din_d;
      addr_q  <= addr_d;
      cnt_q   <= cnt_d;
`ifdef NVRAM_SERVER_RESTORE_EN
      we_q    <= we_d;
      nvd_q   <= nvd_d;
`endif
    end
  end

  assign ioctl_din  = din_q;
  assign ioctl_wait = wait_q;
  assign pause_req  = pause_q;
  assign nv_addr    = addr_q;
`ifdef NVRAM_SERVER_RESTORE_EN
  assign nv_we = we_q;
  assign nv_d  = nvd_q;
`else
  assign nv_we = 1'b0;
  assign nv_d  = 8'd0;
`endif

  nvram_dirty_timer #(
    .NV_AW     (NV_AW),
    .NV_BASE   (NV_BASE),
    .QUIET_CYC (QUIET_CYC)
  ) u_timer (
    .clk_sys    (clk_sys),
    .rst_n      (rst_n),
    .cpu_wr     (cpu_wr),
    .cpu_addr   (cpu_addr),
    .count_en   (autosave && (state_q == IDLE)),
    .save_done  (save_done),
    .upload_req (ioctl_upload_req)
  );

endmodule

// File: tb/tb_nvram_upload_server.sv
// tb_nvram_upload_server: directed bench with a read-data scoreboard.
module tb_nvram_upload_server;
  import nvram_pkg::*;

  localparam int RAM_LAT = 2;

  logic        clk_sys = 1'b0;
  logic        RESET_n;
  logic        ioctl_upload, ioctl_rd, autosave, cpu_wr, paused;
  logic [7:0]  ioctl_index, ioctl_din, nv_q, nv_d;
  logic [24:0] ioctl_addr;
  logic        ioctl_wait, ioctl_upload_req, pause_req, nv_we;
  logic [15:0] cpu_addr;
  logic [9:0]  nv_addr;
`ifdef NVRAM_SERVER_RESTORE_EN
  logic        ioctl_download, ioctl_wr;
  logic [7:0]  ioctl_dout;
  logic [7:0]  wr_mem [0:1023];
`endif

  logic [7:0]  mem [0:1023];
  logic [9:0]  ra_q;
  logic [7:0]  rq_q;
  logic [7:0]  exp_q [$];
  int          total = 0;
  int          bad = 0;

  always #5 clk_sys = ~clk_sys;

  nvram_upload_server #(
    .NV_INDEX(8'd4), .NV_AW(10), .NV_BASE(16'hC000),
    .RAM_LAT(RAM_LAT), .QUIET_CYC(24'd100)
  ) dut (
    .clk_sys(clk_sys), .RESET_n(RESET_n), .ioctl_upload(ioctl_upload),
`ifdef NVRAM_SERVER_RESTORE_EN
    .ioctl_download(ioctl_download), .ioctl_wr(ioctl_wr), .ioctl_dout(ioctl_dout),
`endif
    .ioctl_index(ioctl_index), .ioctl_rd(ioctl_rd), .ioctl_addr(ioctl_addr),
    .ioctl_din(ioctl_din), .ioctl_wait(ioctl_wait),
    .ioctl_upload_req(ioctl_upload_req), .autosave(autosave),
    .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .pause_req(pause_req),
    .paused(paused), .nv_addr(nv_addr), .nv_q(nv_q), .nv_we(nv_we), .nv_d(nv_d)
  );

  // Two-cycle read-latency RAM model
  always @(posedge clk_sys) begin
    ra_q <= nv_addr;
    rq_q <= mem[ra_q];
  end
  assign nv_q = rq_q;

`ifdef NVRAM_SERVER_RESTORE_EN
  always @(posedge clk_sys) if (nv_we) wr_mem[nv_addr] <= nv_d;
`endif

  task automatic tick();
    @(posedge clk_sys);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic do_read(input logic [24:0] a);
    int lat;
    logic [7:0] e;
    exp_q.push_back(mem[a[9:0]]);
    ioctl_rd = 1'b1; ioctl_addr = a;
    tick();
    ioctl_rd = 1'b0;
    check("rd_wait_rise", 32'(ioctl_wait), 1);
    lat = 0;
    while (ioctl_wait === 1'b1 && lat < 20) begin tick(); lat++; end
    check("rd_latency", lat, RAM_LAT + 1);
    e = exp_q.pop_front();
    check("rd_data", 32'(ioctl_din), 32'(e));
  endtask

  task automatic cpu_write(input logic [15:0] a);
    cpu_wr = 1'b1; cpu_addr = a;
    tick();
    cpu_wr = 1'b0;
  endtask

  task automatic count_to_req(output int k);
    k = 0;
    do begin tick(); k++; end while (ioctl_upload_req !== 1'b1 && k < 400);
  endtask

  task automatic watch(input int n, output int pulses);
    pulses = 0;
    for (int i = 0; i < n; i++) begin
      tick();
      if (ioctl_upload_req === 1'b1) pulses++;
    end
  endtask

  initial begin
    int k, p;
    logic [7:0] e;
    for (int i = 0; i < 1024; i++) mem[i] = 8'(i) ^ 8'h3C;
    mem[0] = 8'h5A; mem[1023] = 8'hA5;
    RESET_n = 1'b0; ioctl_upload = 0; ioctl_index = 0; ioctl_rd = 0; ioctl_addr = 0;
    autosave = 0; cpu_wr = 0; cpu_addr = 0; paused = 0;
`ifdef NVRAM_SERVER_RESTORE_EN
    ioctl_download = 0; ioctl_wr = 0; ioctl_dout = 0;
`endif
    tick(); tick();
    check("rst_din",   32'(ioctl_din), 0);
    check("rst_wait",  32'(ioctl_wait), 0);
    check("rst_req",   32'(ioctl_upload_req), 0);
    check("rst_pause", 32'(pause_req), 0);
    check("rst_naddr", 32'(nv_addr), 0);
    check("rst_nwe",   32'(nv_we), 0);
    check("rst_nd",    32'(nv_d), 0);
    RESET_n = 1'b1;
    tick(); tick(); tick();
    check("rst_state", 32'(dut.state_q), 32'(IDLE));

    // Upload start, CPU acknowledges 5 cycles late
    ioctl_index = 8'd4; ioctl_upload = 1'b1;
    tick();
    check("pause_req_rise", 32'(pause_req), 1);
    for (int i = 0; i < 5; i++) begin
      check("wait_until_paused", 32'(ioctl_wait), 1);
      tick();
    end
    paused = 1'b1;
    tick();
    check("ready_wait_low", 32'(ioctl_wait), 0);

    do_read(25'd0);
    do_read(25'd1023);
    do_read(25'd5);

    // Out-of-window read
    exp_q.push_back(8'hFF);
    ioctl_rd = 1'b1; ioctl_addr = 25'd1024;
    tick();
    ioctl_rd = 1'b0;
    e = exp_q.pop_front();
    check("oob_din", 32'(ioctl_din), 32'(e));
    check("oob_wait", 32'(ioctl_wait), 0);
    check("oob_naddr", 32'(nv_addr), 32'd5);
    tick();
    check("oob_wait2", 32'(ioctl_wait), 0);

    // Snooped hit while paused, then drop upload mid-fetch
    cpu_write(16'hC005);
    check("dirty_set", 32'(dut.u_timer.dirty_q), 1);
    ioctl_rd = 1'b1; ioctl_addr = 25'd2;
    tick();
    ioctl_rd = 1'b0;
    tick();
    ioctl_upload = 1'b0;
    tick();
    check("drop_wait", 32'(ioctl_wait), 0);
    check("drop_pause", 32'(pause_req), 0);
    check("drop_state", 32'(dut.state_q), 32'(IDLE));
    check("drop_dirty", 32'(dut.u_timer.dirty_q), 0);
    check("drop_din", 32'(ioctl_din), 32'hFF);
    paused = 1'b0;
    tick();
    check("drop_din_held", 32'(ioctl_din), 32'hFF);

    // Autosave: single pulse 100 cycles after a hit
    autosave = 1'b1;
    cpu_write(16'hC010);
    count_to_req(k);
    check("quiet_delay", k, 100);
    watch(150, p);
    check("single_pulse", p, 0);

    // Misses just below and just above the window
    cpu_write(16'hBFFF);
    cpu_write(16'hC400);
    watch(150, p);
    check("miss_no_pulse", p, 0);

    // Second hit at quiet cycle 99 restarts the count
    cpu_write(16'hC010);
    watch(98, p);
    cpu_write(16'hC3FF);
    check("restart_no_early", p + 32'(ioctl_upload_req), 0);
    count_to_req(k);
    check("restart_delay", k, 100);

    // Hit coinciding with terminal count suppresses the pulse
    cpu_write(16'hC020);
    watch(99, p);
    cpu_write(16'hC021);
    check("tc_hit_suppress", p + 32'(ioctl_upload_req), 0);
    count_to_req(k);
    check("tc_hit_delay", k, 100);

`ifdef NVRAM_SERVER_RESTORE_EN
    autosave = 1'b0;
    ioctl_download = 1'b1;
    tick();
    check("dl_pause", 32'(pause_req), 1);
    paused = 1'b1;
    tick();
    check("dl_ready", 32'(ioctl_wait), 0);
    for (int a = 0; a < 1024; a++) begin
      ioctl_wr = 1'b1; ioctl_addr = 25'(a); ioctl_dout = 8'(a);
      tick();
      ioctl_wr = 1'b0;
      tick();
    end
    ioctl_wr = 1'b1; ioctl_addr = 25'd1024; ioctl_dout = 8'h77;
    tick();
    ioctl_wr = 1'b0;
    check("dl_oob_drop", 32'(nv_we), 0);
    ioctl_download = 1'b0;
    tick();
    check("dl_release", 32'(pause_req), 0);
    paused = 1'b0;
    for (int a = 0; a < 1024; a++) check("dl_byte", 32'(wr_mem[a]), 32'(8'(a)));
`endif

    check("sb_empty", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
